// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, capture bypass from MEM/WB
// and combinational operand forwarding into the ALU.
module id_ex_fwd (
  input  logic [4:0]  rs,
  input  logic [31:0] stored,
  input  logic        exm_reg_write,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] data
);
  always_comb begin
    data = stored;
    // EX/MEM is the younger producer, so it takes precedence over MEM/WB
    if (rs != 5'd0 && exm_reg_write && exm_rd == rs)
      data = exm_result;
    else if (rs != 5'd0 && wb_reg_write && wb_rd == rs)
      data = wb_data;
  end
endmodule

module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_rs1_data,
  input  logic [31:0] id_rs2_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic [3:0]  id_alu_sel,
  input  logic        id_use_pc,
  input  logic        id_use_imm,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  input  logic        ext_stall,
  input  logic        exm_reg_write,
  input  logic [4:0]  exm_rd,
  input  logic [31:0] exm_result,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [31:0] ex_op1,
  output logic [31:0] ex_op2,
  output logic [31:0] ex_store_data,
  output logic [31:0] ex_pc,
  output logic [3:0]  ex_alu_sel,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read
);
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic                      valid;
    logic [31:0]               pc;
    logic [NUM_OPS-1:0][31:0]  rs_data;
    logic [31:0]               imm;
    logic [NUM_OPS-1:0][4:0]   rs_idx;
    logic [4:0]                rd;
    logic [3:0]                alu_sel;
    logic                      use_pc;
    logic                      use_imm;
    logic                      reg_write;
    logic                      mem_read;
  } id_ex_t;

  id_ex_t r, ld;
  logic [NUM_OPS-1:0][4:0]  id_rs_idx;
  logic [NUM_OPS-1:0][31:0] id_rs_data, cap_data, fwd_data;
  logic hazard;

  assign id_rs_idx  = {id_rs2, id_rs1};
  assign id_rs_data = {id_rs2_data, id_rs1_data};

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    // a register being written back this cycle is stale in the regfile read
    assign cap_data[g] = (wb_reg_write && wb_rd != 5'd0 && wb_rd == id_rs_idx[g])
                         ? wb_data : id_rs_data[g];
    id_ex_fwd u_fwd (
      .rs(r.rs_idx[g]), .stored(r.rs_data[g]),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .data(fwd_data[g])
    );
  end

  always_comb begin
    ld           = '0;
    ld.valid     = id_valid;
    ld.pc        = id_pc;
    ld.rs_data   = cap_data;
    ld.imm       = id_imm;
    ld.rs_idx    = id_rs_idx;
    ld.rd        = id_rd;
    ld.alu_sel   = id_alu_sel;
    ld.use_pc    = id_use_pc;
    ld.use_imm   = id_use_imm;
    ld.reg_write = id_reg_write;
    ld.mem_read  = id_mem_read;
  end

  // clears itself once the bubble (valid=0) sits in the stage
  assign hazard = r.valid && r.mem_read && r.rd != 5'd0 && id_valid &&
                  (r.rd == id_rs1 || r.rd == id_rs2);

  assign id_ready = !rst_n || flush || (!ext_stall && !hazard);

  always_ff @(posedge clk) begin
    if (!rst_n)
      r <= '0;
    else if (flush)
      r.valid <= 1'b0;
    else if (!ext_stall) begin
      if (hazard) r.valid <= 1'b0;
      else        r <= ld;
    end
  end

  assign ex_valid      = r.valid;
  assign ex_op1        = r.use_pc  ? r.pc  : fwd_data[0];
  assign ex_op2        = r.use_imm ? r.imm : fwd_data[1];
  assign ex_store_data = fwd_data[1];
  assign ex_pc         = r.pc;
  assign ex_alu_sel    = r.alu_sel;
  assign ex_rd         = r.rd;
  assign ex_reg_write  = r.valid && r.reg_write;
  assign ex_mem_read   = r.valid && r.mem_read;
endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: vector table plus hazard/stall/flush/reset sequences,
// expectations queued on drive and popped after the capturing edge.
module tb_id_ex_stage;
  logic clk = 1'b0, rst_n;
  logic id_valid, id_use_pc, id_use_imm, id_reg_write, id_mem_read;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_alu_sel;
  logic flush, ext_stall, exm_reg_write, wb_reg_write;
  logic [4:0] exm_rd, wb_rd;
  logic [31:0] exm_result, wb_data;
  logic id_ready, ex_valid, ex_reg_write, ex_mem_read;
  logic [31:0] ex_op1, ex_op2, ex_store_data, ex_pc;
  logic [3:0] ex_alu_sel;
  logic [4:0] ex_rd;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_sel(id_alu_sel),
    .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .flush(flush), .ext_stall(ext_stall),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_store_data(ex_store_data), .ex_pc(ex_pc), .ex_alu_sel(ex_alu_sel),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] op1, op2, sd, pc;
    logic [3:0]  alu;
    logic [4:0]  rd;
    logic        rw, mr;
  } exp_t;
  typedef logic [$bits(exp_t)-1:0] cw_t;

  typedef struct {
    logic        v;
    logic [31:0] pc, d1, d2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        upc, uimm, rw, mr;
    logic [31:0] e_op1, e_op2;
  } vec_t;

  int n_pass = 0, n_total = 0;
  exp_t sb_q[$];

  function automatic vec_t mkv(logic v, logic [31:0] pc, logic [4:0] rs1, logic [31:0] d1,
                               logic [4:0] rs2, logic [31:0] d2, logic [4:0] rd,
                               logic [31:0] imm, logic [3:0] alu, logic upc, logic uimm,
                               logic rw, logic mr, logic [31:0] e1, logic [31:0] e2);
    vec_t t;
    t.v = v; t.pc = pc; t.rs1 = rs1; t.d1 = d1; t.rs2 = rs2; t.d2 = d2; t.rd = rd;
    t.imm = imm; t.alu = alu; t.upc = upc; t.uimm = uimm; t.rw = rw; t.mr = mr;
    t.e_op1 = e1; t.e_op2 = e2;
    return t;
  endfunction

  function automatic exp_t exp_of(vec_t t);
    exp_t e;
    e.valid = t.v; e.op1 = t.e_op1; e.op2 = t.e_op2; e.sd = t.d2; e.pc = t.pc;
    e.alu = t.alu; e.rd = t.rd; e.rw = t.v & t.rw; e.mr = t.v & t.mr;
    return e;
  endfunction

  function automatic exp_t cur_out();
    exp_t o;
    o.valid = ex_valid; o.op1 = ex_op1; o.op2 = ex_op2; o.sd = ex_store_data;
    o.pc = ex_pc; o.alu = ex_alu_sel; o.rd = ex_rd; o.rw = ex_reg_write; o.mr = ex_mem_read;
    return o;
  endfunction

  task automatic drive(input vec_t t);
    id_valid = t.v; id_pc = t.pc; id_rs1 = t.rs1; id_rs1_data = t.d1;
    id_rs2 = t.rs2; id_rs2_data = t.d2; id_rd = t.rd; id_imm = t.imm;
    id_alu_sel = t.alu; id_use_pc = t.upc; id_use_imm = t.uimm;
    id_reg_write = t.rw; id_mem_read = t.mr;
  endtask

  task automatic chk(input string name, input cw_t act, input cw_t want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, want);
  endtask

  task automatic chk_sb(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb_q.pop_front();
      chk(name, cw_t'(cur_out()), cw_t'(e));
    end
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  vec_t tbl[6];
  vec_t a, b, c, lw;
  exp_t e;

  initial begin
    tbl[0] = mkv(1, 32'h100, 1, 32'h5, 2, 32'h7, 3, 32'h0, 4'b0011, 0, 0, 1, 0, 32'h5, 32'h7);
    tbl[1] = mkv(1, 32'h104, 6, 32'h1234, 7, 32'h55, 8, 32'hFFFF_FFF0, 4'b0000, 0, 1, 1, 0,
                 32'h1234, 32'hFFFF_FFF0);
    tbl[2] = mkv(1, 32'h108, 9, 32'hA, 10, 32'hB, 11, 32'h40, 4'b0010, 1, 1, 1, 0, 32'h108, 32'h40);
    tbl[3] = mkv(0, 32'h10C, 12, 32'hC, 13, 32'hD, 14, 32'h0, 4'b1010, 0, 0, 1, 0, 32'hC, 32'hD);
    tbl[4] = mkv(1, 32'h110, 0, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0, 32'h0, 4'b0001, 0, 0, 0, 0,
                 32'hFFFF_FFFF, 32'h8000_0000);
    tbl[5] = mkv(1, 32'h114, 15, 32'h3, 16, 32'h4, 17, 32'h0, 4'b0110, 0, 0, 1, 1, 32'h3, 32'h4);

    // reset with busy-looking inputs
    rst_n = 1'b0; flush = 0; ext_stall = 0;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0; wb_reg_write = 0; wb_rd = 0; wb_data = 0;
    drive(mkv(1, 32'hDEAD, 1, 32'h11, 2, 32'h22, 3, 32'h33, 4'b0101, 1, 1, 1, 1, 0, 0));
    sb_q.push_back('0);
    edge1(); edge1();
    chk("reset_ready", cw_t'(id_ready), cw_t'(1'b1));
    chk_sb("reset_outputs");
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(tbl[i]);
      sb_q.push_back(exp_of(tbl[i]));
      edge1();
      chk_sb($sformatf("vec%0d", i));
    end

    // forwarding priority, with the stage held so only the bypass inputs move
    @(negedge clk);
    a = mkv(1, 32'h200, 3, 32'h11, 0, 32'h22, 6, 32'h0, 4'b0000, 0, 0, 1, 0, 32'h11, 32'h22);
    drive(a); sb_q.push_back(exp_of(a));
    edge1();
    chk_sb("fwd_load");
    ext_stall = 1; id_valid = 0;
    exm_reg_write = 1; exm_rd = 3; exm_result = 32'hAA;
    wb_reg_write = 1; wb_rd = 3; wb_data = 32'hBB;
    #1 chk("fwd_exm_wins", cw_t'(ex_op1), cw_t'(32'hAA));
    exm_reg_write = 0;
    #1 chk("fwd_wb", cw_t'(ex_op1), cw_t'(32'hBB));
    exm_reg_write = 1; exm_rd = 0; wb_rd = 0;
    #1 chk("fwd_rd0_op1", cw_t'(ex_op1), cw_t'(32'h11));
    chk("fwd_rd0_op2", cw_t'(ex_op2), cw_t'(32'h22));
    @(negedge clk);
    ext_stall = 0; exm_reg_write = 0; wb_reg_write = 0;

    // load-use bubble
    lw = mkv(1, 32'h300, 1, 32'h0, 2, 32'h0, 5, 32'h8, 4'b0000, 0, 1, 1, 1, 32'h0, 32'h8);
    drive(lw); sb_q.push_back(exp_of(lw));
    edge1();
    chk_sb("lw_load");
    @(negedge clk);
    c = mkv(1, 32'h304, 1, 32'h10, 5, 32'hDEAD, 7, 32'h0, 4'b0000, 0, 0, 1, 0, 32'h10, 32'h55);
    drive(c);
    #1 chk("lu_ready_low", cw_t'(id_ready), cw_t'(1'b0));
    edge1();
    chk("lu_bubble_valid", cw_t'(ex_valid), cw_t'(1'b0));
    chk("lu_bubble_rw", cw_t'({ex_reg_write, ex_mem_read}), cw_t'(2'b00));
    chk("lu_ready_back", cw_t'(id_ready), cw_t'(1'b1));
    @(negedge clk);
    wb_reg_write = 1; wb_rd = 5; wb_data = 32'h55;
    e = exp_of(c); e.sd = 32'h55; sb_q.push_back(e);
    edge1();
    chk_sb("lu_consumer");
    wb_reg_write = 0;
    #1 chk("lu_captured", cw_t'(ex_op2), cw_t'(32'h55));

    // flush beats stall
    @(negedge clk);
    drive(mkv(1, 32'h400, 1, 32'h1, 2, 32'h2, 3, 32'h0, 4'b0000, 0, 0, 1, 0, 0, 0));
    flush = 1; ext_stall = 1;
    #1 chk("flush_ready", cw_t'(id_ready), cw_t'(1'b1));
    edge1();
    chk("flush_valid", cw_t'(ex_valid), cw_t'(1'b0));
    @(negedge clk);
    flush = 0; ext_stall = 0;
    a = mkv(1, 32'h500, 20, 32'h100, 21, 32'h200, 22, 32'h0, 4'b0100, 0, 0, 1, 0, 32'h100, 32'h200);
    drive(a); sb_q.push_back(exp_of(a));
    edge1();
    chk_sb("stall_a");
    @(negedge clk);
    ext_stall = 1;
    b = mkv(1, 32'h504, 23, 32'h300, 24, 32'h400, 25, 32'h0, 4'b0101, 0, 0, 1, 0, 32'h300, 32'h400);
    drive(b);
    #1 chk("stall_ready", cw_t'(id_ready), cw_t'(1'b0));
    for (int k = 0; k < 3; k++) begin
      sb_q.push_back(exp_of(a));
      edge1();
      chk_sb($sformatf("stall_hold%0d", k));
    end
    @(negedge clk);
    ext_stall = 0; sb_q.push_back(exp_of(b));
    edge1();
    chk_sb("stall_release");

    // capture bypass
    @(negedge clk);
    a = mkv(1, 32'h600, 4, 32'h1, 0, 32'h0, 8, 32'h0, 4'b0000, 0, 0, 1, 0, 32'h9, 32'h0);
    drive(a); wb_reg_write = 1; wb_rd = 4; wb_data = 32'h9;
    sb_q.push_back(exp_of(a));
    edge1();
    wb_reg_write = 0;
    #1 chk_sb("capture_bypass");

    // reset while stalled discards the held instruction
    @(negedge clk);
    a = mkv(1, 32'h700, 26, 32'h77, 27, 32'h88, 28, 32'h0, 4'b0111, 0, 0, 1, 1, 32'h77, 32'h88);
    drive(a); sb_q.push_back(exp_of(a));
    edge1();
    chk_sb("pre_reset");
    @(negedge clk);
    ext_stall = 1; rst_n = 0;
    #1 chk("rst_stall_ready", cw_t'(id_ready), cw_t'(1'b1));
    sb_q.push_back('0);
    edge1();
    chk_sb("rst_stall_outputs");
    @(negedge clk);
    rst_n = 1; ext_stall = 0;
    b = mkv(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0);
    drive(b); sb_q.push_back(exp_of(b));
    edge1();
    chk_sb("no_replay");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
